// File: rtl/mux_striping_n_pkg.sv
// Shared constants and width helper for the N-lane round-robin striping mux.
package mux_striping_pkg;

   localparam int unsigned MODE_RESYNC = 0;
   localparam int unsigned MODE_HOLD   = 1;

   // Ceiling log2, used for lane-pointer and FIFO-pointer widths.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(v)) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/mux_striping_n_lane_fifo.sv
// Per-lane input FIFO; pointers carry one extra wrap bit to tell full from empty.
module lane_fifo
   import mux_striping_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk_nf,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = clog2(DEPTH);

   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk_nf or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   // Storage is data-path only; validity is tracked by the pointers.
   always_ff @(posedge clk_nf) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/mux_striping_n.sv
// Round-robin merge of LANES buffered lanes into one valid/ready stream.
// Optional lane-skew stall counter enabled by MUX_STRIPING_N_STALL_CNT_EN.
module mux_striping_n
   import mux_striping_pkg::*;
#(
   parameter int unsigned LANES = 2,
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned MODE  = 0
) (
   input  logic                      clk_nf,
   input  logic                      reset,
   input  logic [LANES*WIDTH-1:0]    lane_data,
   input  logic [LANES-1:0]          lane_valid,
   output logic [LANES-1:0]          lane_ready,
   input  logic                      out_ready,
   output logic [WIDTH-1:0]          data_output,
   output logic                      valid_out,
   output logic [clog2(LANES)-1:0]   lane_sel_out,
   output logic                      resync_pulse
`ifdef MUX_STRIPING_N_STALL_CNT_EN
   ,
   output logic [15:0]               stall_cnt
`endif
);

   localparam int unsigned PW = clog2(LANES);

   logic [PW-1:0]    ptr;
   logic [PW-1:0]    ptr_nxt;
   logic [WIDTH-1:0] data_nxt;
   logic             valid_nxt;
   logic [PW-1:0]    sel_nxt;
   logic             resync_nxt;
   logic             load_c;
   logic             skew_c;

   logic [WIDTH-1:0] head [LANES];
   logic [LANES-1:0] full;
   logic [LANES-1:0] empty;
   logic [LANES-1:0] push;
   logic [LANES-1:0] pop;

   assign lane_ready = ~full;
   assign load_c     = !valid_out || out_ready;
   assign skew_c     = |(~empty & ~(LANES'(1) << ptr));

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      assign push[i] = lane_valid[i] && !full[i];
      assign pop[i]  = load_c && !empty[i] && (ptr == PW'(i));

      lane_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
         .clk_nf (clk_nf),
         .reset  (reset),
         .push   (push[i]),
         .pop    (pop[i]),
         .wdata  (lane_data[i*WIDTH +: WIDTH]),
         .head   (head[i]),
         .full   (full[i]),
         .empty  (empty[i])
      );
   end

   // Next-state for pointer and output stage; everything holds while stalled.
   always_comb begin
      ptr_nxt    = ptr;
      data_nxt   = data_output;
      valid_nxt  = valid_out;
      sel_nxt    = lane_sel_out;
      resync_nxt = 1'b0;
      if (load_c) begin
         if (!empty[ptr]) begin
            data_nxt  = head[ptr];
            valid_nxt = 1'b1;
            sel_nxt   = ptr;
            ptr_nxt   = (ptr == PW'(LANES-1)) ? '0 : ptr + PW'(1);
         end else begin
            valid_nxt = 1'b0;
            if (MODE == MODE_RESYNC) begin
               ptr_nxt    = '0;
               resync_nxt = (ptr != '0);
            end
         end
      end
   end

   always_ff @(posedge clk_nf or negedge reset) begin
      if (!reset) begin
         ptr          <= '0;
         data_output  <= '0;
         valid_out    <= 1'b0;
         lane_sel_out <= '0;
         resync_pulse <= 1'b0;
      end else begin
         ptr          <= ptr_nxt;
         data_output  <= data_nxt;
         valid_out    <= valid_nxt;
         lane_sel_out <= sel_nxt;
         resync_pulse <= resync_nxt;
      end
   end

`ifdef MUX_STRIPING_N_STALL_CNT_EN
   // Counts load cycles starved by the current lane while another lane has data.
   always_ff @(posedge clk_nf or negedge reset) begin
      if (!reset) begin
         stall_cnt <= '0;
      end else if (load_c && empty[ptr] && skew_c && (stall_cnt != 16'hFFFF)) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end
`else
   logic unused_skew;
   assign unused_skew = skew_c;
`endif

endmodule

// File: doc/mux_striping_n.md
Name: mux_striping_n

Overview:
- Parametrised successor to the two-lane striping mux: merges LANES parallel lanes into one serial stream in strict round-robin order (lane 0, 1, ..., LANES-1, 0, ...).
- Each lane has a small input FIFO with valid/ready backpressure; the output stage uses valid/ready.
- Sits between the per-lane byte-striping logic and the serializer.
- Runs on clk_nf, which is LANES times the per-lane rate.

Parameters:
- LANES, 2: number of input lanes (2..8).
- WIDTH, 32: data width per lane and at the output.
- DEPTH, 4: entries per lane FIFO (power of 2, minimum 2).
- MODE, 0: empty-lane policy. 0 = resync (pointer returns to lane 0); 1 = hold (pointer waits on the empty lane).

Ports:
- clk_nf, input, 1: block clock, LANES x lane rate.
- reset, input, 1: asynchronous, active-low reset.
- lane_data, input, LANES*WIDTH: lane i occupies bits [i*WIDTH +: WIDTH].
- lane_valid, input, LANES: per-lane data valid.
- lane_ready, output, LANES: per-lane FIFO not full.
- out_ready, input, 1: downstream accepts data_output.
- data_output, output, WIDTH: serial output word.
- valid_out, output, 1: data_output valid.
- lane_sel_out, output, clog2(LANES): source lane of the current data_output.
- resync_pulse, output, 1: one-cycle flag for a round-robin resync (MODE 0 only).

Behaviour:
- Reset (reset low, asynchronous): clears all FIFOs, sets ptr=0 and data_output=0, and drives valid_out, lane_sel_out and resync_pulse to 0.
- Release of reset takes effect on the next rising edge. A reset asserted mid-stream discards all buffered data.
- Lane FIFO:
  - lane_ready[i] = !full[i] (registered state only, no combinational path from inputs).
  - A push occurs when lane_valid[i] && lane_ready[i].
  - No bypass: a word pushed at edge k is poppable at edge k+1 at the earliest.
- Output load condition: load = !valid_out || out_ready. While valid_out && !out_ready, data_output, lane_sel_out and ptr hold unchanged.
- On load with FIFO[ptr] non-empty:
  - pop FIFO[ptr];
  - data_output <= head, valid_out <= 1, lane_sel_out <= ptr;
  - ptr <= (ptr == LANES-1) ? 0 : ptr+1.
- On load with FIFO[ptr] empty:
  - valid_out <= 0.
  - MODE 0: ptr <= 0. resync_pulse <= 1 only if ptr != 0; an empty lane 0 does not pulse.
  - MODE 1: ptr holds and resync_pulse stays 0.
- resync_pulse is 0 in every other cycle.
- Latency: a word accepted at edge k appears on data_output after edge k+1 if ptr points at its lane and the output stage is free.
- Throughput: one word per clk_nf when all lanes are non-empty and out_ready is high.
- Simultaneous push and pop on one lane:
  - Allowed when the FIFO is not full; occupancy is unchanged.
  - When full, the push is refused (lane_ready low) and the pop frees a slot for the next cycle.
- FIFO read and write pointers wrap modulo DEPTH. Full/empty detection uses an extra pointer bit.

Optional Feature:
- Macro: MUX_STRIPING_N_STALL_CNT_EN.
- When defined: adds output port stall_cnt [15:0], reset to 0.
  - Increments on every load cycle where FIFO[ptr] is empty and at least one other lane FIFO is non-empty (a lane-skew stall).
  - Saturates at 16'hFFFF.
- When undefined: the port and logic are absent, and all other behaviour is identical.

Decomposition:
- Package mux_striping_pkg holds:
  - constants MODE_RESYNC=0 and MODE_HOLD=1;
  - a clog2 helper function for the ptr and FIFO-pointer widths.
- Sub-module lane_fifo (WIDTH and DEPTH parameters; push/pop/full/empty/head interface) is instantiated LANES times via generate.
- Round-robin pointer and output register stay in the top.

Test Plan (LANES=4, WIDTH=8, DEPTH=4):
- Ordered stripe: lanes 0..3 push 8'h10..8'h13 at the same edge, out_ready=1 -> data_output 10, 11, 12, 13 on four consecutive cycles; lane_sel_out 0, 1, 2, 3; valid_out continuously 1.
- MODE 0 gap: lanes 0, 1, 3 hold data and lane 2 is empty when ptr=2 -> one cycle with valid_out=0 and resync_pulse=1; next output comes from lane 0.
- MODE 1 gap: same stimulus -> valid_out=0 until lane 2 is pushed with 8'hA2, then outputs A2 followed by lane 3 data; resync_pulse never asserts.
- Backpressure: out_ready=0 for 6 cycles while lane 1 pushes each cycle -> data_output stable; lane_ready[1] goes 0 after 4 accepted words; after release, words drain in order with none lost.
- Reset mid-stream: assert reset asynchronously between edges with valid_out=1 -> valid_out, data_output and lane_sel_out go to 0 immediately; after release, the first output comes from lane 0.
- With MUX_STRIPING_N_STALL_CNT_EN defined: three skew stalls -> stall_cnt=3; preloaded near max -> holds at 16'hFFFF.
